os2ip_stream: RTL and testbench

Streaming, parametrised octet-string-to-integer converter (PKCS#1 OS2IP) for the RSA datapath. Accepts the octet string MS-octet-first as a valid/ready beat stream of `BEAT_BYTES` octets per beat, accumulates x = x·256^k + octets, and presents the full `DATA_BIT_WIDTH` integer with octet length and error status on a held output handshake. It sits between the message framer and the modular-exponentiation input, replacing the single-cycle fixed-width converter.

---
 rtl/os2ip_pkg.sv | 46 ++++
 rtl/os2ip_beat_decode.sv | 31 +++
 rtl/os2ip_stream.sv | 110 +++++++++++
 tb/tb_os2ip_stream.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/os2ip_pkg.sv
// Shared types, status bit indices and keep-mask helpers for the streaming OS2IP converter.
package os2ip_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } os2ip_state_e;

  localparam int unsigned OS2IP_ST_OVF   = 0;
  localparam int unsigned OS2IP_ST_FMT   = 1;
  localparam int unsigned OS2IP_KEEP_MAX = 64;
  localparam int unsigned OS2IP_KEEP_IW  = $clog2(OS2IP_KEEP_MAX);

  // Number of set bits among the low n bits of keep.
  function automatic int unsigned keep_popcount(input logic [OS2IP_KEEP_MAX-1:0] keep,
                                                input int unsigned n);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < OS2IP_KEEP_MAX; i++) begin
      if (i < n && keep[OS2IP_KEEP_IW'(i)]) cnt = cnt + 1;
    end
    return cnt;
  endfunction

  // True when the low n bits are ones packed against bit n-1 (or all zero).
  function automatic logic keep_is_contiguous(input logic [OS2IP_KEEP_MAX-1:0] keep,
                                              input int unsigned n);
    logic seen_zero;
    logic ok;
    int unsigned idx;
    seen_zero = 1'b0;
    ok        = 1'b1;
    for (int unsigned i = 0; i < OS2IP_KEEP_MAX; i++) begin
      if (i < n) begin
        idx = n - 1 - i;
        if (keep[OS2IP_KEEP_IW'(idx)]) begin
          if (seen_zero) ok = 1'b0;
        end else begin
          seen_zero = 1'b1;
        end
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/os2ip_beat_decode.sv
// Combinational beat decode: octet count, right-aligned kept octets and keep legality.
module os2ip_beat_decode
  import os2ip_pkg::*;
#(
  parameter int unsigned BEAT_BYTES = 4,
  localparam int unsigned KW = $clog2(BEAT_BYTES + 1)
) (
  input  logic [8*BEAT_BYTES-1:0] s_data,
  input  logic [BEAT_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  output logic [KW-1:0]           k_c,
  output logic [8*BEAT_BYTES-1:0] octets_c,
  output logic                    legal_c
);

  localparam int unsigned BW = 8 * BEAT_BYTES;
  localparam int unsigned SW = $clog2(BW + 1);

  logic          contig;
  logic [SW-1:0] shamt;

  // Kept octets sit at the top of the beat; shifting down drops the unkept tail.
  always_comb begin
    k_c      = KW'(keep_popcount(OS2IP_KEEP_MAX'(s_keep), BEAT_BYTES));
    contig   = keep_is_contiguous(OS2IP_KEEP_MAX'(s_keep), BEAT_BYTES);
    shamt    = SW'((BEAT_BYTES - 32'(k_c)) * 8);
    octets_c = s_data >> shamt;
    legal_c  = contig && (s_last || (32'(k_c) == BEAT_BYTES));
  end

endmodule

// File: rtl/os2ip_stream.sv
// Streaming octet-string-to-integer converter: accumulates MS-first beats, holds the result.
module os2ip_stream
  import os2ip_pkg::*;
#(
  parameter int unsigned DATA_BIT_WIDTH = 2048,
  parameter int unsigned BEAT_BYTES     = 4,
  parameter int unsigned LEN_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [8*BEAT_BYTES-1:0]   s_data,
  input  logic [BEAT_BYTES-1:0]     s_keep,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_BIT_WIDTH-1:0] m_x,
  output logic [LEN_WIDTH-1:0]      m_len,
  output logic [1:0]                m_status
);

  localparam int unsigned KW  = $clog2(BEAT_BYTES + 1);
  localparam int unsigned SW  = $clog2(DATA_BIT_WIDTH + 1);
  localparam int unsigned LW1 = LEN_WIDTH + 1;

  os2ip_state_e              state, state_n;
  logic [DATA_BIT_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]      len;
  logic [1:0]                status;

  logic [KW-1:0]             k_c;
  logic [8*BEAT_BYTES-1:0]   octets_c;
  logic                      legal_c;
  logic                      accept_c;
  logic                      ovf_c;
  logic [SW-1:0]             up_shamt_c, down_shamt_c;
  logic [DATA_BIT_WIDTH-1:0] acc_next_c;
  logic [LW1-1:0]            len_sum_c;
  logic [LEN_WIDTH-1:0]      len_next_c;

  os2ip_beat_decode #(.BEAT_BYTES(BEAT_BYTES)) u_decode (
    .s_data   (s_data),
    .s_keep   (s_keep),
    .s_last   (s_last),
    .k_c      (k_c),
    .octets_c (octets_c),
    .legal_c  (legal_c)
  );

  // s_ready is only ever high in ACCUM, so it alone qualifies acceptance.
  assign accept_c = s_valid && s_ready;

  // Shift-in of k octets; overflow when any of the bits shifted out were set.
  always_comb begin
    up_shamt_c   = SW'(8 * 32'(k_c));
    down_shamt_c = SW'(DATA_BIT_WIDTH - 8 * 32'(k_c));
    ovf_c        = |(acc >> down_shamt_c);
    acc_next_c   = (acc << up_shamt_c) | DATA_BIT_WIDTH'(octets_c);
    len_sum_c    = {1'b0, len} + LW1'(k_c);
    len_next_c   = len_sum_c[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : len_sum_c[LEN_WIDTH-1:0];
  end

  always_comb begin
    state_n = state;
    case (state)
      ACCUM:   if (accept_c && s_last) state_n = HOLD;
      HOLD:    if (m_ready) state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  // Handshake flags track the next state so they are registered, not combinational.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ACCUM;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      state   <= state_n;
      s_ready <= (state_n == ACCUM);
      m_valid <= (state_n == HOLD);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      len    <= '0;
      status <= '0;
    end else if (state == HOLD && m_ready) begin
      acc    <= '0;
      len    <= '0;
      status <= '0;
    end else if (accept_c) begin
      if (legal_c) begin
        acc                  <= acc_next_c;
        len                  <= len_next_c;
        status[OS2IP_ST_OVF] <= status[OS2IP_ST_OVF] | ovf_c;
      end else begin
        status[OS2IP_ST_FMT] <= 1'b1;
      end
    end
  end

  assign m_x      = acc;
  assign m_len    = len;
  assign m_status = status;

endmodule

// File: tb/tb_os2ip_stream.sv
// Self-checking bench for os2ip_stream at 64-bit width, 4 octets per beat.
module tb_os2ip_stream;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        m_valid, m_ready;
  logic [63:0] m_x;
  logic [15:0] m_len;
  logic [1:0]  m_status;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];

  os2ip_stream #(.DATA_BIT_WIDTH(64), .BEAT_BYTES(4), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_len(m_len), .m_status(m_status)
  );

  always #5 clk = ~clk;

  // Reference: octet-at-a-time big-integer build following the OS2IP rules.
  function automatic void ref_model(output logic [63:0] x, output int len, output logic [1:0] st);
    x = '0; len = 0; st = '0;
    foreach (q_data[i]) begin
      int n;
      int mask;
      n = 0;
      for (int b = 0; b < 4; b++) if (q_keep[i][b]) n++;
      mask = (32'hF << (4 - n)) & 32'hF;
      if (32'(q_keep[i]) != mask || (!q_last[i] && n != 4)) st[1] = 1'b1;
      else begin
        for (int j = 0; j < n; j++) begin
          logic [7:0] oct;
          oct = 8'(q_data[i] >> (24 - 8 * j));
          if (x[63:56] != 8'h00) st[0] = 1'b1;
          x = {x[55:0], oct};
          if (len < 65535) len++;
        end
      end
    end
  endfunction

  task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    q_data.push_back(d); q_keep.push_back(k); q_last.push_back(l);
  endtask

  task automatic clear_q();
    q_data.delete(); q_keep.delete(); q_last.delete();
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l, output bit ok);
    int  n;
    bit  rdy;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    n = 0;
    do begin
      rdy = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 200);
    ok = rdy;
  endtask

  task automatic send_queued(input int gap_pct, output bit ok);
    bit b_ok;
    ok = 1'b1;
    foreach (q_data[i]) begin
      while ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      drive_beat(q_data[i], q_keep[i], q_last[i], b_ok);
      ok &= b_ok;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [63:0] x, output logic [15:0] len,
                             output logic [1:0] st, output bit ok);
    int n;
    n = 0;
    while (m_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (m_valid === 1'b1);
    x = m_x; len = m_len; st = m_status;
  endtask

  task automatic consume();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_x !== 64'h0 || m_len !== 16'h0 || m_status !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b m_x=%h m_len=%0d m_status=%b, required all zero",
               s_ready, m_valid, m_x, m_len, m_status);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %b, required 0 before first edge", s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_rise: got %b, required 1", s_ready);
    end
  endtask

  // Directed message with constant expectations.
  task automatic run_directed(input string name, input logic [63:0] ex, input logic [15:0] el,
                              input logic [1:0] es);
    logic [63:0] x; logic [15:0] l; logic [1:0] st; bit ok;
    send_queued(0, ok);
    checks++;
    if (!ok || m_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency: accepted=%b m_valid=%b s_ready=%b, required 1 1 0", name, ok, m_valid, s_ready);
    end
    wait_result(x, l, st, ok);
    checks++;
    if (!ok || x !== ex || l !== el || st !== es) begin
      errors++;
      $display("FAIL %s_result: valid=%b x=%h len=%0d st=%b, required x=%h len=%0d st=%b",
               name, ok, x, l, st, ex, el, es);
    end
    consume();
    clear_q();
  endtask

  task automatic test_basic();
    clear_q();
    push_beat(32'h01020304, 4'b1111, 1'b0); push_beat(32'h05060708, 4'b1111, 1'b1);
    run_directed("two_beats", 64'h0102030405060708, 16'd8, 2'b00);
    push_beat(32'hABCD0000, 4'b1100, 1'b1);
    run_directed("partial", 64'hABCD, 16'd2, 2'b00);
    push_beat(32'h12345678, 4'b0000, 1'b1);
    run_directed("empty", 64'h0, 16'd0, 2'b00);
  endtask

  task automatic test_overflow();
    push_beat(32'h0, 4'hF, 1'b0); push_beat(32'h0, 4'hF, 1'b0); push_beat(32'h1, 4'hF, 1'b1);
    run_directed("lead_zeros", 64'h1, 16'd12, 2'b00);
    push_beat(32'h1, 4'hF, 1'b0); push_beat(32'h0, 4'hF, 1'b0); push_beat(32'h0, 4'hF, 1'b1);
    run_directed("overflow", 64'h0, 16'd12, 2'b01);
  endtask

  task automatic test_format();
    push_beat(32'hFF00FF00, 4'b1010, 1'b1);
    run_directed("noncontig", 64'h0, 16'd0, 2'b10);
    push_beat(32'h11223344, 4'b1100, 1'b0); push_beat(32'hAABBCCDD, 4'b1111, 1'b1);
    run_directed("partial_nonlast", 64'hAABBCCDD, 16'd4, 2'b10);
  endtask

  task automatic test_backpressure();
    logic [63:0] x; logic [15:0] l; logic [1:0] st; bit ok; bit stable;
    push_beat(32'h01020304, 4'hF, 1'b1);
    send_queued(0, ok);
    clear_q();
    s_valid = 1'b1; s_data = 32'hDEADBEEF; s_keep = 4'hF; s_last = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_x !== 64'h01020304 || m_len !== 16'd4) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_stable: m_valid=%b s_ready=%b m_x=%h m_len=%0d, required 1 0 01020304 4",
               m_valid, s_ready, m_x, m_len);
    end
    consume();
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: s_ready=%b m_valid=%b, required 1 0", s_ready, m_valid);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_result(x, l, st, ok);
    checks++;
    if (!ok || x !== 64'hDEADBEEF || l !== 16'd4 || st !== 2'b00) begin
      errors++;
      $display("FAIL after_hold: valid=%b x=%h len=%0d st=%b, required DEADBEEF 4 00", ok, x, l, st);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    bit ok;
    drive_beat(32'h11111111, 4'hF, 1'b0, ok);
    s_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_x !== 64'h0 || m_len !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: s_ready=%b m_valid=%b m_x=%h m_len=%0d, required 0 0 0 0",
               s_ready, m_valid, m_x, m_len);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    push_beat(32'h11223344, 4'hF, 1'b1);
    run_directed("post_reset", 64'h11223344, 16'd4, 2'b00);
  endtask

  task automatic test_len_saturate();
    logic [63:0] x; logic [15:0] l; logic [1:0] st; bit ok; bit all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 16400; i++) begin
      drive_beat(32'h0, 4'hF, (i == 16399), ok);
      all_ok &= ok;
    end
    s_valid = 1'b0;
    wait_result(x, l, st, ok);
    checks++;
    if (!all_ok || !ok || x !== 64'h0 || l !== 16'hFFFF || st !== 2'b00) begin
      errors++;
      $display("FAIL len_saturate: accepted=%b valid=%b x=%h len=%0d st=%b, required 0 65535 00",
               all_ok, ok, x, l, st);
    end
    consume();
  endtask

  task automatic test_random();
    logic [3:0]  last_pat [6];
    logic [63:0] x, ex; logic [15:0] l; logic [1:0] st, es; int el; bit ok, sent;
    last_pat[0] = 4'b0000; last_pat[1] = 4'b1000; last_pat[2] = 4'b1100;
    last_pat[3] = 4'b1110; last_pat[4] = 4'b1111; last_pat[5] = 4'b1111;
    for (int m = 0; m < 40; m++) begin
      int nb;
      clear_q();
      nb = $urandom_range(6, 1);
      for (int b = 0; b < nb; b++) begin
        logic [31:0] d; logic [3:0] k; logic lst;
        lst = (b == nb - 1);
        d = ($urandom_range(3) == 0) ? 32'h0 : 32'($urandom);
        if ($urandom_range(9) == 0) k = 4'($urandom);
        else if (lst) k = last_pat[$urandom_range(5)];
        else k = 4'hF;
        push_beat(d, k, lst);
      end
      ref_model(ex, el, es);
      send_queued(20, sent);
      wait_result(x, l, st, ok);
      checks++;
      if (!sent || !ok || x !== ex || l !== 16'(el) || st !== es) begin
        errors++;
        $display("FAIL random_msg%0d: valid=%b x=%h len=%0d st=%b, required x=%h len=%0d st=%b",
                 m, ok, x, l, st, ex, el, es);
      end
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      consume();
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_format();
    test_backpressure();
    test_reset_mid();
    test_len_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
